fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch front end for one core.
- Holds the PC, drives the byte address to the core's combinational instruction memory, and captures the returned word into the IF/ID pipeline register.
- Handles stall (hold), flush/redirect (branch/jump from EX), and counts delivered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INS, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or reset.
- CNT_W, 32, width of the delivered-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  EX: take redirect_target next cycle
- redirect_target  in  32  EX: new byte PC
- imem_addr  out  32  byte address to instruction memory (word index = addr[11:2])
- imem_data  in  32  instruction word returned combinationally same cycle
- if_id_ins  out  32  registered instruction to decode
- if_id_pc  out  32  registered PC of if_id_ins
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  CNT_W  number of instructions delivered to IF/ID
- misalign_trap  out  1  (optional feature only) registered misaligned-target flag

Behaviour:
- One clock, all state on posedge clk; reset is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - pc=RESET_PC
  - if_id_ins=NOP_INS
  - if_id_pc=0
  - if_id_valid=0
  - fetch_count=0
  - misalign_trap=0
- imem_addr = pc, combinational, no extra logic. Memory read is zero-latency, so imem_data belongs to the current pc.
- Per cycle, priority order: rst > redirect_valid > stall > normal.
  - Normal (no stall, no redirect):
    - if_id_ins <= imem_data
    - if_id_pc <= pc
    - if_id_valid <= 1
    - pc <= pc + 4
    - fetch_count increments
  - Stall only: pc, IF/ID and fetch_count all hold. imem_addr stays stable.
  - Redirect (with or without stall):
    - pc <= aligned target
    - if_id_ins <= NOP_INS, if_id_valid <= 0, if_id_pc <= 0
    - fetch_count holds
    - The wrong-path word at the old pc is discarded.
- Latency:
  - Instruction at PC p appears on if_id_ins one cycle after pc==p.
  - After a redirect, the first target instruction is valid in IF/ID 2 cycles after redirect_valid is sampled (one bubble).
- Alignment: target bits [1:0] are forced to 2'b00 before loading pc.
- Arithmetic: pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). fetch_count wraps modulo 2^CNT_W. Instruction memory aliases every 4 KiB; this block does not bound the PC.
- Reset mid-stall or mid-redirect: reset wins, and the next cycle fetches at RESET_PC.
- No state machine beyond the valid bit. After reset, the first fetch happens in the first cycle with rst=0.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with target[1:0] != 0 sets misalign_trap <= 1 on that edge.
  - PC still loads the aligned target.
  - misalign_trap is sticky until rst.
  - The IF/ID bubble is inserted as usual.
- Undefined:
  - No misalign_trap port.
  - Misaligned low bits are silently dropped.

Decomposition:
- Shared package core_pkg:
  - XLEN=32
  - NOP_INS
  - RESET_PC default
  - INS_W=32
  - pc_t / ins_t typedefs, shared with decode and EX.
- One natural sub-module: if_id_reg, the pipeline register with hold (stall) and clear-to-NOP (flush). Decode-side pipeline registers reuse it.
- Next-PC mux stays inline.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: rst for 2 cycles, then release; memory word[0..3] = 0x00500093, 0x00A00113, 0x002081B3, 0x00000013.
  - Required response: imem_addr goes 0,4,8,C; if_id_ins follows one cycle later; if_id_valid=1 from the 2nd post-reset cycle; fetch_count=3 after 3 deliveries.
- Stall:
  - Stimulus: stall=1 for 3 cycles while pc=0x8.
  - Required response: pc stays 0x8; if_id_ins/if_id_pc stay frozen at the 0x4 entry; fetch_count unchanged; normal flow resumes the cycle after the stall drops.
- Redirect:
  - Stimulus: redirect_valid with target 0x40 while pc=0x10.
  - Required response: next cycle pc=0x40, if_id_valid=0, if_id_ins=0x00000013; the following cycle if_id_pc=0x40 with valid=1.
- Redirect + stall same cycle:
  - Stimulus: redirect_valid=1 and stall=1 together, target 0x80.
  - Required response: pc=0x80; IF/ID is flushed, not held.
- Wrap:
  - Stimulus: force RESET_PC=32'hFFFF_FFFC.
  - Required response: the next pc is 0x0; no X on any output.
- Misaligned target:
  - Stimulus: target 0x22.
  - With FETCH_MISALIGN_TRAP_EN: pc=0x20 and misalign_trap=1, held until rst.
  - Without the macro: pc=0x20 and no trap port.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for fetch, decode and EX
package core_pkg;

   localparam int XLEN  = 32;
   localparam int INS_W = 32;

   typedef logic [XLEN-1:0]  pc_t;
   typedef logic [INS_W-1:0] ins_t;

   // addi x0,x0,0 used as the pipeline bubble
   localparam ins_t NOP_INS          = 32'h0000_0013;
   localparam pc_t  RESET_PC_DEFAULT = 32'h0000_0000;

   // Instructions are word aligned; low two target bits are dropped
   function automatic pc_t align_pc(input pc_t target);
      return target & ~pc_t'(3);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory bus between fetch and a combinational imem
interface fetch_unit_if;
   import core_pkg::*;

   pc_t  imem_addr;
   ins_t imem_data;

   modport master (output imem_addr, input imem_data);
   modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - pipeline register with hold and clear-to-NOP
module if_id_reg
   import core_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic hold_i,
   input  logic flush_i,
   input  ins_t ins_i,
   input  pc_t  pc_i,
   output ins_t ins_o,
   output pc_t  pc_o,
   output logic valid_o
);

   ins_t ins_q, ins_d;
   pc_t  pc_q, pc_d;
   logic valid_q, valid_d;

   // Flush beats hold so a redirect during a stall still drops the wrong path
   always_comb begin
      ins_d   = ins_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush_i) begin
         ins_d   = NOP_INS;
         pc_d    = '0;
         valid_d = 1'b0;
      end else if (!hold_i) begin
         ins_d   = ins_i;
         pc_d    = pc_i;
         valid_d = 1'b1;
      end
   end

   // Register update; reset loads a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         ins_q   <= NOP_INS;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         ins_q   <= ins_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign ins_o   = ins_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, imem addressing and IF/ID capture; FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect flag
module fetch_unit
   import core_pkg::*;
#(
   parameter pc_t RESET_PC = RESET_PC_DEFAULT,
   parameter int  CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  pc_t              redirect_target,
   fetch_unit_if.master     imem,
   output ins_t             if_id_ins,
   output pc_t              if_id_pc,
   output logic             if_id_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic             misalign_trap,
`endif
   output logic [CNT_W-1:0] fetch_count
);

   pc_t              pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             advance;

   // A fetch is delivered only when neither redirect nor stall is active
   assign advance = !redirect_valid && !stall;

   // Next-PC mux and delivered-instruction counter
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      if (redirect_valid) begin
         pc_d = align_pc(redirect_target);
      end else if (!stall) begin
         pc_d  = pc_q + pc_t'(4);
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // PC and counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   // Memory is zero-latency, so imem_data belongs to pc_q in this cycle
   assign imem.imem_addr = pc_q;
   assign fetch_count    = cnt_q;

   if_id_reg u_if_id (
      .clk     (clk),
      .rst     (rst),
      .hold_i  (stall),
      .flush_i (redirect_valid),
      .ins_i   (imem.imem_data),
      .pc_i    (pc_q),
      .ins_o   (if_id_ins),
      .pc_o    (if_id_pc),
      .valid_o (if_id_valid)
   );

`ifdef FETCH_MISALIGN_TRAP_EN
   logic trap_q, trap_d;

   // Sticky flag set by any redirect whose target is not word aligned
   always_comb begin
      trap_d = trap_q;
      if (redirect_valid && (redirect_target[1:0] != 2'b00)) trap_d = 1'b1;
   end

   // Trap register, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) trap_q <= 1'b0;
      else     trap_q <= trap_d;
   end

   assign misalign_trap = trap_q;
`endif

   logic unused_advance;
   assign unused_advance = advance;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed hand-computed vectors
module tb_fetch_unit;
   import core_pkg::*;

   typedef struct {
      logic       rst;
      logic       stall;
      logic       rv;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [31:0] e_ifpc;
      logic       e_valid;
      logic [31:0] e_cnt;
      logic       e_trap;
      logic [31:0] e_wpc;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        w_stall = 1'b0;
   logic        w_rv = 1'b0;
   logic [31:0] w_tgt = '0;

   logic [31:0] mem [0:1023];

   fetch_unit_if imem_bus ();
   fetch_unit_if wrap_bus ();

   assign imem_bus.imem_data = mem[imem_bus.imem_addr[11:2]];
   assign wrap_bus.imem_data = mem[wrap_bus.imem_addr[11:2]];

   logic [31:0] if_id_ins, if_id_pc, fetch_count;
   logic        if_id_valid;
   logic [31:0] w_ins, w_ifpc, w_cnt;
   logic        w_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_trap, w_trap;
`endif

   fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem            (imem_bus.master),
      .if_id_ins       (if_id_ins),
      .if_id_pc        (if_id_pc),
      .if_id_valid     (if_id_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misalign_trap   (misalign_trap),
`endif
      .fetch_count     (fetch_count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk             (clk),
      .rst             (rst),
      .stall           (w_stall),
      .redirect_valid  (w_rv),
      .redirect_target (w_tgt),
      .imem            (wrap_bus.master),
      .if_id_ins       (w_ins),
      .if_id_pc        (w_ifpc),
      .if_id_valid     (w_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misalign_trap   (w_trap),
`endif
      .fetch_count     (w_cnt)
   );

   vec_t vecs[$];
   vec_t expq[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   task automatic add(input logic r, input logic s, input logic v, input logic [31:0] t,
                      input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ifpc,
                      input logic val, input logic [31:0] cnt, input logic trap,
                      input logic [31:0] wpc);
      vec_t e;
      e.rst = r; e.stall = s; e.rv = v; e.tgt = t;
      e.e_pc = pc; e.e_ins = ins; e.e_ifpc = ifpc; e.e_valid = val;
      e.e_cnt = cnt; e.e_trap = trap; e.e_wpc = wpc;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
      end
   endtask

   // Stimulus: drive a row at negedge and post its expected post-edge state
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | i;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      mem[2] = 32'h0020_81B3;
      mem[3] = 32'h0000_0013;

      //   rst stl rv  tgt           pc            ins           ifpc          v  cnt trap wrap_pc
      add(1, 0, 0, 32'h0,        32'h0,        32'h13,       32'h0,        0, 0, 0, 32'hFFFF_FFFC);
      add(1, 0, 0, 32'h0,        32'h0,        32'h13,       32'h0,        0, 0, 0, 32'hFFFF_FFFC);
      add(0, 0, 0, 32'h0,        32'h4,        32'h0050_0093, 32'h0,       1, 1, 0, 32'h0);
      add(0, 0, 0, 32'h0,        32'h8,        32'h00A0_0113, 32'h4,       1, 2, 0, 32'h4);
      add(0, 1, 0, 32'h0,        32'h8,        32'h00A0_0113, 32'h4,       1, 2, 0, 32'h8);
      add(0, 1, 0, 32'h0,        32'h8,        32'h00A0_0113, 32'h4,       1, 2, 0, 32'hC);
      add(0, 1, 0, 32'h0,        32'h8,        32'h00A0_0113, 32'h4,       1, 2, 0, 32'h10);
      add(0, 0, 0, 32'h0,        32'hC,        32'h0020_81B3, 32'h8,       1, 3, 0, 32'h14);
      add(0, 0, 0, 32'h0,        32'h10,       32'h13,       32'hC,        1, 4, 0, 32'h18);
      add(0, 0, 1, 32'h40,       32'h40,       32'h13,       32'h0,        0, 4, 0, 32'h1C);
      add(0, 0, 0, 32'h0,        32'h44,       32'hC000_0010, 32'h40,      1, 5, 0, 32'h20);
      add(0, 1, 1, 32'h80,       32'h80,       32'h13,       32'h0,        0, 5, 0, 32'h24);
      add(0, 1, 0, 32'h0,        32'h80,       32'h13,       32'h0,        0, 5, 0, 32'h28);
      add(0, 0, 0, 32'h0,        32'h84,       32'hC000_0020, 32'h80,      1, 6, 0, 32'h2C);
      add(0, 0, 1, 32'h22,       32'h20,       32'h13,       32'h0,        0, 6, 1, 32'h30);
      add(0, 0, 0, 32'h0,        32'h24,       32'hC000_0008, 32'h20,      1, 7, 1, 32'h34);
      add(0, 0, 1, 32'hFFC,      32'hFFC,      32'h13,       32'h0,        0, 7, 1, 32'h38);
      add(0, 0, 0, 32'h0,        32'h1000,     32'hC000_03FF, 32'hFFC,     1, 8, 1, 32'h3C);
      add(0, 0, 0, 32'h0,        32'h1004,     32'h0050_0093, 32'h1000,    1, 9, 1, 32'h40);
      add(1, 1, 1, 32'h40,       32'h0,        32'h13,       32'h0,        0, 0, 0, 32'hFFFF_FFFC);
      add(0, 0, 0, 32'h0,        32'h4,        32'h0050_0093, 32'h0,       1, 1, 0, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst             = vecs[i].rst;
         stall           = vecs[i].stall;
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].tgt;
         expq.push_back(vecs[i]);
      end
      stim_done = 1'b1;
   end

   // Monitor: one expected entry per clock edge, compared just after the edge
   initial begin
      int row = 0;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() != 0) begin
            vec_t e;
            e = expq.pop_front();
            chk("imem_addr",   row, imem_bus.imem_addr, e.e_pc);
            chk("if_id_ins",   row, if_id_ins, e.e_ins);
            chk("if_id_pc",    row, if_id_pc, e.e_ifpc);
            chk("if_id_valid", row, {31'b0, if_id_valid}, {31'b0, e.e_valid});
            chk("fetch_count", row, fetch_count, e.e_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("misalign_trap", row, {31'b0, misalign_trap}, {31'b0, e.e_trap});
`endif
            chk("wrap_pc",     row, wrap_bus.imem_addr, e.e_wpc);
            checks++;
            if ($isunknown({imem_bus.imem_addr, if_id_ins, if_id_pc, if_id_valid, fetch_count,
                            wrap_bus.imem_addr, w_ins, w_ifpc, w_valid, w_cnt})) begin
               errors++;
               $display("FAIL row %0d xcheck: unknown bits on an output", row);
            end
            row++;
         end
      end
   end

   // Completion with a bounded wait for the scoreboard to drain
   initial begin
      int budget = 0;
      wait (stim_done);
      while (expq.size() != 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      repeat (2) @(posedge clk);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
